// File: rtl/nanorv32_dataif_resp.sv
// -----------------------------------------------------------------------------
// nanorv32_dataif_resp
//
// Purpose:
//   Bridges the nanorv32 CPU data interface to a single-port synchronous SRAM.
//   A request is accepted in IDLE, optionally delayed by WAIT_STATES cycles,
//   performed in a single ACCESS cycle, and completed with a one-cycle RESP
//   pulse. Sub-word writes are expanded into byte-lane enables with replicated
//   write data; sub-word reads are extracted from the returned word and
//   zero-extended. Misaligned, illegal-size and out-of-range requests are not
//   sent to the SRAM; they complete with the same timing and an error flag.
//
// Parameters:
//   WAIT_STATES  extra wait cycles before the SRAM access (0..15)
//   MEM_AW       SRAM word-address width (1..29)
//
// Ports:
//   clk                     in   1       rising-edge clock
//   rst                     in   1       synchronous active-high reset
//   cpu_dataif_valid        in   1       request, held until ready
//   cpu_dataif_addr         in   32      byte address
//   cpu_dataif_we           in   1       1 = write, 0 = read
//   cpu_dataif_size         in   2       0 byte, 1 half, 2 word, 3 illegal
//   cpu_dataif_wdata        in   32      right-justified write data
//   dataif_cpu_early_ready  out  1       pulse one cycle before ready
//   dataif_cpu_ready        out  1       one-cycle completion pulse
//   dataif_cpu_rdata        out  32      zero-extended read data (with ready)
//   dataif_cpu_err          out  1       error flag (with ready)
//   mem_en                  out  1       SRAM access strobe
//   mem_we                  out  4       SRAM byte-lane write enables
//   mem_addr                out  MEM_AW  SRAM word address
//   mem_wdata               out  32      SRAM write data
//   mem_rdata               in   32      SRAM read data, one cycle after mem_en
// -----------------------------------------------------------------------------
module nanorv32_dataif_resp #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned MEM_AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_dataif_valid,
    input  logic [31:0]       cpu_dataif_addr,
    input  logic              cpu_dataif_we,
    input  logic [1:0]        cpu_dataif_size,
    input  logic [31:0]       cpu_dataif_wdata,
    output logic              dataif_cpu_early_ready,
    output logic              dataif_cpu_ready,
    output logic [31:0]       dataif_cpu_rdata,
    output logic              dataif_cpu_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Byte-address width covered by the SRAM.
    localparam int unsigned AW = MEM_AW + 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // The acceptance cycle counts as wait cycle 0, so WAIT holds cycles
    // 1..WAIT_STATES-1 and leaves on the last one. Unused when WAIT_STATES < 2.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    // Captured request and control state.
    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic          r_illegal;

    // Request decode and datapath.
    logic          w_in_illegal;
    logic          w_use_in;
    logic [AW-1:0] w_req_addr;
    logic          w_req_we;
    logic [1:0]    w_req_size;
    logic [31:0]   w_req_wdata;
    logic          w_req_illegal;
    logic          w_access;
    logic          w_resp;
    logic          w_mem_en;
    logic [3:0]    w_lanes;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_rd_shift;
    logic [31:0]   w_rd_data;

    // Legality of the request currently on the CPU inputs. Anything above the
    // SRAM's byte range is rejected as well as misalignment and size 3.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_in_illegal = 1'b0;
        case (cpu_dataif_size)
            SZ_BYTE: w_in_illegal = 1'b0;
            SZ_HALF: w_in_illegal = cpu_dataif_addr[0];
            SZ_WORD: w_in_illegal = |cpu_dataif_addr[1:0];
            default: w_in_illegal = 1'b1;
        endcase
        if ((cpu_dataif_addr >> AW) != 32'd0) begin
            w_in_illegal = 1'b1;
        end
    end

    // With no wait states the access happens in the acceptance cycle, straight
    // from the CPU inputs; otherwise everything comes from the captured copy.
    assign w_use_in = (WAIT_STATES == 0) && (r_state == S_IDLE)
                      && cpu_dataif_valid && !rst;

    assign w_req_addr    = w_use_in ? cpu_dataif_addr[AW-1:0] : r_addr;
    assign w_req_we      = w_use_in ? cpu_dataif_we           : r_we;
    assign w_req_size    = w_use_in ? cpu_dataif_size         : r_size;
    assign w_req_wdata   = w_use_in ? cpu_dataif_wdata        : r_wdata;
    assign w_req_illegal = w_use_in ? w_in_illegal            : r_illegal;

    // Outputs are forced quiet while rst is high, even before the reset edge.
    assign w_access = !rst && ((r_state == S_ACCESS) || w_use_in);
    assign w_resp   = !rst && (r_state == S_RESP);
    assign w_mem_en = w_access && !w_req_illegal;

    // Write lane enables and replicated write data.
    always_comb begin
        w_lanes     = 4'b0000;
        w_wdata_rep = 32'd0;
        case (w_req_size)
            SZ_BYTE: begin
                w_lanes     = 4'b0001 << w_req_addr[1:0];
                w_wdata_rep = {4{w_req_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_lanes     = w_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{w_req_wdata[15:0]}};
            end
            default: begin
                w_lanes     = 4'b1111;
                w_wdata_rep = w_req_wdata;
            end
        endcase
    end

    // Read extraction in RESP: shift the addressed lane down to bit 0. For a
    // legal halfword addr[0] is 0, so the same shift selects the half.
    assign w_rd_shift = mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_rd_data = 32'd0;
        case (r_size)
            SZ_BYTE: w_rd_data = {24'd0, w_rd_shift[7:0]};
            SZ_HALF: w_rd_data = {16'd0, w_rd_shift[15:0]};
            default: w_rd_data = mem_rdata;
        endcase
    end

    assign dataif_cpu_early_ready = w_access;
    assign mem_en                 = w_mem_en;
    assign mem_we                 = (w_mem_en && w_req_we) ? w_lanes : 4'b0000;
    assign mem_addr               = rst ? '0 : w_req_addr[AW-1:2];
    assign mem_wdata              = rst ? 32'd0 : w_wdata_rep;

    assign dataif_cpu_ready = w_resp;
    assign dataif_cpu_err   = w_resp && r_illegal;
    assign dataif_cpu_rdata = (w_resp && !r_illegal && !r_we) ? w_rd_data : 32'd0;

    // Sequencer. The captured request is cleared on reset so the SRAM-side
    // address and data outputs read zero until the next request.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_wdata   <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_dataif_valid) begin
                        r_addr    <= cpu_dataif_addr[AW-1:0];
                        r_we      <= cpu_dataif_we;
                        r_size    <= cpu_dataif_size;
                        r_wdata   <= cpu_dataif_wdata;
                        r_illegal <= w_in_illegal;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                        end else if (WAIT_STATES == 1) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_RESP;
                end
                default: begin
                    // RESP always returns to IDLE; valid is re-sampled there.
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nanorv32_dataif_resp.sv
// -----------------------------------------------------------------------------
// tb_nanorv32_dataif_resp
//
// Three instances (WAIT_STATES = 0, 1, 2) share one set of CPU inputs and one
// mem_rdata value. Each scenario drives the inputs, records every output of
// every instance at the negative edge of each cycle, then compares the record
// against hand-computed expectations. Instance d has WAIT_STATES = d, so its
// ACCESS cycle is d and its RESP cycle is d+1 after acceptance.
// -----------------------------------------------------------------------------
module tb_nanorv32_dataif_resp;

    localparam int NC = 12;  // recorded cycles per scenario
    localparam int NV = 12;  // directed transfer vectors

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;

    logic        d_er    [3];
    logic        d_rdy   [3];
    logic [31:0] d_rdata [3];
    logic        d_err   [3];
    logic        d_en    [3];
    logic [3:0]  d_we    [3];
    logic [9:0]  d_addr  [3];
    logic [31:0] d_wdata [3];

    logic        s_er    [3][NC];
    logic        s_rdy   [3][NC];
    logic [31:0] s_rdata [3][NC];
    logic        s_err   [3][NC];
    logic        s_en    [3][NC];
    logic [3:0]  s_we    [3][NC];
    logic [9:0]  s_addr  [3][NC];
    logic [31:0] s_wdata [3][NC];

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [3:0]  xwe;
        logic [9:0]  xaddr;
        logic [31:0] xwdata;
        logic [31:0] xrdata;
        logic        xerr;
    } vec_t;

    vec_t vecs [NV];

    nanorv32_dataif_resp #(.WAIT_STATES(0), .MEM_AW(10)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_dataif_valid(valid), .cpu_dataif_addr(addr), .cpu_dataif_we(we),
        .cpu_dataif_size(size), .cpu_dataif_wdata(wdata),
        .dataif_cpu_early_ready(d_er[0]), .dataif_cpu_ready(d_rdy[0]),
        .dataif_cpu_rdata(d_rdata[0]), .dataif_cpu_err(d_err[0]),
        .mem_en(d_en[0]), .mem_we(d_we[0]), .mem_addr(d_addr[0]),
        .mem_wdata(d_wdata[0]), .mem_rdata(mem_rdata)
    );

    nanorv32_dataif_resp #(.WAIT_STATES(1), .MEM_AW(10)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_dataif_valid(valid), .cpu_dataif_addr(addr), .cpu_dataif_we(we),
        .cpu_dataif_size(size), .cpu_dataif_wdata(wdata),
        .dataif_cpu_early_ready(d_er[1]), .dataif_cpu_ready(d_rdy[1]),
        .dataif_cpu_rdata(d_rdata[1]), .dataif_cpu_err(d_err[1]),
        .mem_en(d_en[1]), .mem_we(d_we[1]), .mem_addr(d_addr[1]),
        .mem_wdata(d_wdata[1]), .mem_rdata(mem_rdata)
    );

    nanorv32_dataif_resp #(.WAIT_STATES(2), .MEM_AW(10)) u_dut2 (
        .clk(clk), .rst(rst),
        .cpu_dataif_valid(valid), .cpu_dataif_addr(addr), .cpu_dataif_we(we),
        .cpu_dataif_size(size), .cpu_dataif_wdata(wdata),
        .dataif_cpu_early_ready(d_er[2]), .dataif_cpu_ready(d_rdy[2]),
        .dataif_cpu_rdata(d_rdata[2]), .dataif_cpu_err(d_err[2]),
        .mem_en(d_en[2]), .mem_we(d_we[2]), .mem_addr(d_addr[2]),
        .mem_wdata(d_wdata[2]), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample all instances at the negative edge of cycle c, then advance to
    // just after the next rising edge, where the following cycle's inputs go.
    task automatic record(input int c);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            s_er[d][c]    = d_er[d];
            s_rdy[d][c]   = d_rdy[d];
            s_rdata[d][c] = d_rdata[d];
            s_err[d][c]   = d_err[d];
            s_en[d][c]    = d_en[d];
            s_we[d][c]    = d_we[d];
            s_addr[d][c]  = d_addr[d];
            s_wdata[d][c] = d_wdata[d];
        end
        @(posedge clk);
        #1;
    endtask

    // Inputs that would produce a visible access if they were not ignored.
    task automatic drive_garbage();
        valid = 1'b0;
        addr  = 32'hFFFF_FFFF;
        we    = ~we;
        size  = 2'd3;
        wdata = 32'h5A5A_5A5A;
    endtask

    // Reset holds every output low, even with a request on the inputs. Ends
    // with rst released, so the next task's request arrives in that cycle.
    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b1;
        addr  = 32'h10;
        we    = 1'b1;
        size  = 2'd2;
        wdata = 32'h1234_5678;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        record(0);
        record(1);
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if ((s_er[d][c] !== 1'b0) || (s_rdy[d][c] !== 1'b0) || (s_en[d][c] !== 1'b0)
                    || (s_err[d][c] !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL reset_ctrl dut%0d cyc%0d: got er=%b rdy=%b en=%b err=%b expected all 0",
                             d, c, s_er[d][c], s_rdy[d][c], s_en[d][c], s_err[d][c]);
                end
                n_checks++;
                if ((s_we[d][c] !== 4'h0) || (s_addr[d][c] !== 10'h0) || (s_wdata[d][c] !== 32'h0)
                    || (s_rdata[d][c] !== 32'h0)) begin
                    n_fail++;
                    $display("FAIL reset_data dut%0d cyc%0d: got we=%h addr=%h wdata=%h rdata=%h expected all 0",
                             d, c, s_we[d][c], s_addr[d][c], s_wdata[d][c], s_rdata[d][c]);
                end
            end
        end
        rst   = 1'b0;
        valid = 1'b0;
    endtask

    // Directed single transfers: one-cycle valid, inputs scrambled afterwards.
    task automatic test_transfers(input int first, input int last);
        logic       exp_acc;
        logic       exp_rsp;
        logic       exp_en;
        logic [3:0] exp_we;
        for (int v = first; v <= last; v++) begin
            valid     = 1'b1;
            addr      = vecs[v].addr;
            we        = vecs[v].we;
            size      = vecs[v].size;
            wdata     = vecs[v].wdata;
            mem_rdata = vecs[v].mrd;
            record(0);
            drive_garbage();
            for (int c = 1; c < 5; c++) record(c);
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < 5; c++) begin
                    exp_acc = (c == d);
                    exp_rsp = (c == d + 1);
                    exp_en  = exp_acc && !vecs[v].xerr;
                    exp_we  = (exp_en && vecs[v].we) ? vecs[v].xwe : 4'h0;
                    n_checks++;
                    if (s_er[d][c] !== exp_acc) begin
                        n_fail++;
                        $display("FAIL early_ready v%0d dut%0d cyc%0d: got %b expected %b",
                                 v, d, c, s_er[d][c], exp_acc);
                    end
                    n_checks++;
                    if (s_en[d][c] !== exp_en) begin
                        n_fail++;
                        $display("FAIL mem_en v%0d dut%0d cyc%0d: got %b expected %b",
                                 v, d, c, s_en[d][c], exp_en);
                    end
                    n_checks++;
                    if (s_we[d][c] !== exp_we) begin
                        n_fail++;
                        $display("FAIL mem_we v%0d dut%0d cyc%0d: got %h expected %h",
                                 v, d, c, s_we[d][c], exp_we);
                    end
                    n_checks++;
                    if (s_rdy[d][c] !== exp_rsp) begin
                        n_fail++;
                        $display("FAIL ready v%0d dut%0d cyc%0d: got %b expected %b",
                                 v, d, c, s_rdy[d][c], exp_rsp);
                    end
                    n_checks++;
                    if (s_err[d][c] !== (exp_rsp && vecs[v].xerr)) begin
                        n_fail++;
                        $display("FAIL err v%0d dut%0d cyc%0d: got %b expected %b",
                                 v, d, c, s_err[d][c], exp_rsp && vecs[v].xerr);
                    end
                    n_checks++;
                    if (s_rdata[d][c] !== (exp_rsp ? vecs[v].xrdata : 32'h0)) begin
                        n_fail++;
                        $display("FAIL rdata v%0d dut%0d cyc%0d: got %h expected %h",
                                 v, d, c, s_rdata[d][c], exp_rsp ? vecs[v].xrdata : 32'h0);
                    end
                    if (exp_en) begin
                        n_checks++;
                        if (s_addr[d][c] !== vecs[v].xaddr) begin
                            n_fail++;
                            $display("FAIL mem_addr v%0d dut%0d cyc%0d: got %h expected %h",
                                     v, d, c, s_addr[d][c], vecs[v].xaddr);
                        end
                    end
                    if (exp_en && vecs[v].we) begin
                        n_checks++;
                        if (s_wdata[d][c] !== vecs[v].xwdata) begin
                            n_fail++;
                            $display("FAIL mem_wdata v%0d dut%0d cyc%0d: got %h expected %h",
                                     v, d, c, s_wdata[d][c], vecs[v].xwdata);
                        end
                    end
                end
            end
        end
    endtask

    // Valid held high for cycles 0..7: an out-of-range read first, then a
    // legal word read at 0x20. Each instance re-accepts every N+2 cycles and
    // only the first transaction (k = 0) is in error.
    task automatic test_back_to_back();
        logic        e_er;
        logic        e_en;
        logic        e_rdy;
        logic        e_err;
        logic [31:0] e_rd;
        int          p;
        valid     = 1'b1;
        addr      = 32'h1000;
        we        = 1'b0;
        size      = 2'd2;
        wdata     = 32'h0;
        mem_rdata = 32'h0BAD_F00D;
        record(0);
        addr = 32'h20;
        for (int c = 1; c < NC; c++) begin
            if (c == 8) valid = 1'b0;
            record(c);
        end
        for (int d = 0; d < 3; d++) begin
            p = d + 2;
            for (int c = 0; c < NC; c++) begin
                e_er = 1'b0; e_en = 1'b0; e_rdy = 1'b0; e_err = 1'b0; e_rd = 32'h0;
                for (int k = 0; k * p <= 7; k++) begin
                    if (c == k * p + d) begin
                        e_er = 1'b1;
                        e_en = (k > 0);
                    end
                    if (c == k * p + d + 1) begin
                        e_rdy = 1'b1;
                        e_err = (k == 0);
                        e_rd  = (k > 0) ? 32'h0BAD_F00D : 32'h0;
                    end
                end
                n_checks++;
                if ((s_er[d][c] !== e_er) || (s_en[d][c] !== e_en) || (s_rdy[d][c] !== e_rdy)
                    || (s_err[d][c] !== e_err)) begin
                    n_fail++;
                    $display("FAIL b2b_ctrl dut%0d cyc%0d: got er=%b en=%b rdy=%b err=%b expected er=%b en=%b rdy=%b err=%b",
                             d, c, s_er[d][c], s_en[d][c], s_rdy[d][c], s_err[d][c], e_er, e_en, e_rdy, e_err);
                end
                n_checks++;
                if (s_rdata[d][c] !== e_rd) begin
                    n_fail++;
                    $display("FAIL b2b_rdata dut%0d cyc%0d: got %h expected %h", d, c, s_rdata[d][c], e_rd);
                end
                if (e_en) begin
                    n_checks++;
                    if (s_addr[d][c] !== 10'h008) begin
                        n_fail++;
                        $display("FAIL b2b_addr dut%0d cyc%0d: got %h expected 008", d, c, s_addr[d][c]);
                    end
                end
            end
        end
    endtask

    // Reset asserted in cycle 1 (WAIT for N=2, ACCESS for N=1, RESP for N=0):
    // every in-flight transaction is dropped with no pulse of any kind.
    task automatic test_reset_in_wait();
        valid     = 1'b1;
        addr      = 32'h10;
        we        = 1'b0;
        size      = 2'd2;
        wdata     = 32'h0;
        mem_rdata = 32'hDEAD_BEEF;
        record(0);
        valid = 1'b0;
        rst   = 1'b1;
        record(1);
        record(2);
        rst = 1'b0;
        record(3);
        record(4);
        for (int d = 0; d < 3; d++) begin
            for (int c = 1; c < 5; c++) begin
                n_checks++;
                if ((s_er[d][c] !== 1'b0) || (s_rdy[d][c] !== 1'b0) || (s_en[d][c] !== 1'b0)
                    || (s_we[d][c] !== 4'h0) || (s_err[d][c] !== 1'b0) || (s_rdata[d][c] !== 32'h0)) begin
                    n_fail++;
                    $display("FAIL rst_wait dut%0d cyc%0d: got er=%b rdy=%b en=%b we=%h err=%b rdata=%h expected all 0",
                             d, c, s_er[d][c], s_rdy[d][c], s_en[d][c], s_we[d][c], s_err[d][c], s_rdata[d][c]);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        valid    = 1'b0;
        addr     = 32'h0;
        we       = 1'b0;
        size     = 2'd0;
        wdata    = 32'h0;
        mem_rdata = 32'h0;

        //             addr          we    size  wdata         mem_rdata     xwe    xaddr    xwdata        xrdata        xerr
        vecs[0]  = '{32'h0000_0010, 1'b0, 2'd2, 32'h0,        32'hDEAD_BEEF, 4'h0, 10'h004, 32'h0,        32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{32'h0000_0003, 1'b1, 2'd0, 32'h1234_56A5, 32'hFFFF_FFFF, 4'h8, 10'h000, 32'hA5A5_A5A5, 32'h0,        1'b0};
        vecs[2]  = '{32'h0000_0006, 1'b0, 2'd1, 32'h0,        32'h1234_5678, 4'h0, 10'h001, 32'h0,        32'h0000_1234, 1'b0};
        vecs[3]  = '{32'h0000_0002, 1'b0, 2'd2, 32'h0,        32'h1234_5678, 4'h0, 10'h000, 32'h0,        32'h0,        1'b1};
        vecs[4]  = '{32'h0000_1000, 1'b0, 2'd2, 32'h0,        32'h1234_5678, 4'h0, 10'h000, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{32'h0000_0002, 1'b1, 2'd1, 32'h0000_BEEF, 32'h0,        4'hC, 10'h000, 32'hBEEF_BEEF, 32'h0,        1'b0};
        vecs[6]  = '{32'h0000_0005, 1'b0, 2'd0, 32'h0,        32'h1122_3344, 4'h0, 10'h001, 32'h0,        32'h0000_0033, 1'b0};
        vecs[7]  = '{32'h0000_0000, 1'b0, 2'd3, 32'h0,        32'h1122_3344, 4'h0, 10'h000, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{32'h0000_0001, 1'b0, 2'd1, 32'h0,        32'h1122_3344, 4'h0, 10'h000, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{32'h0000_03FC, 1'b1, 2'd2, 32'hCAFE_F00D, 32'h0,        4'hF, 10'h0FF, 32'hCAFE_F00D, 32'h0,        1'b0};
        vecs[10] = '{32'h0000_0001, 1'b1, 2'd2, 32'h0000_0055, 32'h0,        4'h0, 10'h000, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{32'h0000_0FFF, 1'b0, 2'd0, 32'h0,        32'hA1B2_C3D4, 4'h0, 10'h3FF, 32'h0,        32'h0000_00A1, 1'b0};

        test_reset();
        test_transfers(0, NV - 1);
        test_back_to_back();
        test_reset_in_wait();
        test_transfers(0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
